// File: rtl/apb3_pkg.sv
// rtl/apb3_pkg.sv - shared types and defaults for the APB3 initiator
// Purpose: FSM state enum, default bus widths and timeout counter sizing helper.
// Ports: none (package).
package apb3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb3_state_e;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
  function automatic int ctr_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb3_initiator_if.sv
// rtl/apb3_initiator_if.sv - command, response and APB3 signal bundle
// Purpose: groups the command channel, response channel and APB3 master port.
// Ports: master modport = initiator view (drives CMD_READY, RSP_*, PADDR/PSEL/PENABLE/PWRITE/PWDATA);
//        slave modport  = requester + completer view (drives CMD_*, RSP_READY, PRDATA/PREADY/PSLVERR).
interface apb3_initiator_if
  import apb3_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_AW,
  parameter int DATA_WIDTH = APB_DW
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_WDATA;

  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  RSP_TIMEOUT;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb3_timeout_ctr.sv
// rtl/apb3_timeout_ctr.sv - ACCESS-phase wait-state counter with expiry flag
// Purpose: counts stalled ACCESS cycles; expire_o marks the last allowed cycle.
// Ports: clk_i, rst_i (sync active-high), clr_i (zero count), en_i (count one cycle),
//        expire_o (count == TIMEOUT_CYCLES-1; never asserted when TIMEOUT_CYCLES == 0).
module apb3_timeout_ctr
  import apb3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW      = ctr_width(TIMEOUT_CYCLES);
  localparam bit            ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LAST    = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = ENABLED && (cnt_q == LAST);

endmodule

// File: rtl/apb3_initiator.sv
// rtl/apb3_initiator.sv - single-outstanding command-to-APB3 initiator
// Purpose: accepts one command, runs APB3 SETUP/ACCESS, returns data/error/timeout on RSP.
// Ports: PCLK, PRESET (sync active-high), bus (apb3_initiator_if.master: CMD_*, RSP_*, APB3 master).
module apb3_initiator
  import apb3_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_AW,
  parameter int DATA_WIDTH     = APB_DW,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb3_initiator_if.master bus
);

  apb3_state_e           state_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  pwrite_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_expire;

  // SETUP always precedes ACCESS, so clearing there zeroes the count on ACCESS entry.
  assign tmo_clr = (state_q == SETUP);
  assign tmo_en  = (state_q == ACCESS) && !bus.PREADY;

  apb3_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .expire_o(tmo_expire)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.CMD_VALID) begin
            paddr_q  <= bus.CMD_ADDR;
            pwdata_q <= bus.CMD_WDATA;
            pwrite_q <= bus.CMD_WRITE;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a completion on the final count beats the abort.
          if (bus.PREADY) begin
            rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
            rsp_err_q     <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (tmo_expire) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CMD_READY   = (state_q == IDLE);
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.RSP_VALID   = rsp_valid_q;
  assign bus.RSP_RDATA   = rsp_rdata_q;
  assign bus.RSP_ERR     = rsp_err_q;
  assign bus.RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_initiator.sv
// tb/tb_apb3_initiator.sv - scoreboard bench for apb3_initiator
module tb_apb3_initiator;
  localparam int NEVER = 1000;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          en;
  } apb_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];

  int          cfg_waits;
  logic [31:0] cfg_rdata;
  logic        cfg_err;
  bit          ignore_apb;

  apb3_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb3_initiator #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Completer: decides PREADY for the coming edge; drives noise on PRDATA/PSLVERR when not ready.
  int acc;
  always @(negedge clk) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (acc == cfg_waits) begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = cfg_rdata;
        bus.PSLVERR = cfg_err;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hBAD0_0000 + acc;
        bus.PSLVERR = 1'b1;
      end
      acc++;
    end else begin
      acc         = 0;
      bus.PREADY  = 1'b0;
      bus.PRDATA  = 32'h0BAD_0BAD;
      bus.PSLVERR = 1'b1;
    end
  end

  // Monitor: APB stability, ACCESS length and response scoreboard.
  int en_cnt;
  bit prev_pen;
  always @(negedge clk) begin
    if (rst) begin
      en_cnt   = 0;
      prev_pen = 1'b0;
    end else begin
      if (bus.PSEL) begin
        if (apb_q.size() > 0) begin
          chk("paddr", bus.PADDR, apb_q[0].addr);
          chk("pwrite", bus.PWRITE, apb_q[0].wr);
          chk("pwdata", bus.PWDATA, apb_q[0].wdata);
        end else if (!ignore_apb) begin
          chk("apb_unexpected_psel", 1, 0);
        end
      end
      if (bus.PENABLE) begin
        en_cnt++;
      end else if (prev_pen) begin
        if (apb_q.size() > 0) begin
          apb_exp_t a;
          a = apb_q.pop_front();
          chk("penable_cycles", en_cnt, a.en);
        end else if (!ignore_apb) begin
          chk("apb_unexpected_access", 1, 0);
        end
        en_cnt = 0;
      end
      prev_pen = bus.PENABLE;
      if (bus.RSP_VALID && bus.RSP_READY) begin
        if (rsp_q.size() > 0) begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          chk("rsp_rdata", bus.RSP_RDATA, r.rdata);
          chk("rsp_err", bus.RSP_ERR, r.err);
          chk("rsp_timeout", bus.RSP_TIMEOUT, r.tmo);
        end else begin
          chk("rsp_unexpected", 1, 0);
        end
      end
    end
  end

  task automatic present(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdata, input logic slverr,
                         input bit track, input int exp_en,
                         input logic [31:0] exp_rdata, input logic exp_err, input logic exp_tmo);
    apb_exp_t a;
    rsp_exp_t r;
    @(negedge clk);
    cfg_waits     = waits;
    cfg_rdata     = rdata;
    cfg_err       = slverr;
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_WDATA = wdata;
    if (track) begin
      a.addr = addr; a.wr = wr; a.wdata = wdata; a.en = exp_en;
      r.rdata = exp_rdata; r.err = exp_err; r.tmo = exp_tmo;
      apb_q.push_back(a);
      rsp_q.push_back(r);
    end
  endtask

  task automatic accept(output int acc_cyc);
    int n;
    n = 0;
    while (!bus.CMD_READY && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.CMD_READY) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.CMD_VALID = 1'b0;
    @(negedge clk);
    chk("setup_psel", bus.PSEL, 1);
    chk("setup_penable", bus.PENABLE, 0);
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rdata, input logic slverr,
                      input int exp_en, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic exp_tmo, output int acc_cyc);
    present(wr, addr, wdata, waits, rdata, slverr, 1'b1, exp_en, exp_rdata, exp_err, exp_tmo);
    accept(acc_cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() > 0 || apb_q.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", rsp_q.size() + apb_q.size(), 0);
  endtask

  initial begin
    int t0, t1, t2, n;
    checks = 0; errors = 0; cyc = 0; ignore_apb = 1'b0;
    cfg_waits = 0; cfg_rdata = '0; cfg_err = 1'b0;
    bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0; bus.CMD_WDATA = '0;
    bus.RSP_READY = 1'b1;
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_rsp_valid", bus.RSP_VALID, 0);
    chk("rst_cmd_ready", bus.CMD_READY, 1);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_rsp_err", {bus.RSP_ERR, bus.RSP_TIMEOUT}, 0);
    rst = 1'b0;

    // wr, addr, wdata, waits, prdata, pslverr, exp ACCESS cycles, exp rdata, err, timeout
    send(1, 32'h0000_3004, 32'hA5A5_1234, 0, 32'h1111_1111, 0, 1, 32'h0, 0, 0, t0);
    drain();
    send(0, 32'h0000_1000, 32'h0, 3, 32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 0, 0, t0);
    drain();
    send(0, 32'h0000_2008, 32'h0, 0, 32'h1234_5678, 1, 1, 32'h1234_5678, 1, 0, t0);
    drain();
    send(0, 32'h0000_4000, 32'h0, NEVER, 32'h5555_AAAA, 0, 8, 32'h0, 1, 1, t0);
    drain();
    send(0, 32'h0000_4004, 32'h0, 7, 32'h0BAD_F00D, 0, 8, 32'h0BAD_F00D, 0, 0, t0);
    drain();
    send(1, 32'h0000_5010, 32'hCAFE_0001, 2, 32'h7777_7777, 1, 3, 32'h0, 1, 0, t0);
    drain();
    send(1, 32'h0000_6020, 32'h0F0F_F0F0, NEVER, 32'h0, 0, 8, 32'h0, 1, 1, t0);
    drain();

    // Back-pressure: hold RSP_READY low while a second command waits.
    @(posedge clk); #1 bus.RSP_READY = 1'b0;
    send(0, 32'h0000_7000, 32'h0, 1, 32'h2468_ACE0, 0, 2, 32'h2468_ACE0, 0, 0, t0);
    n = 0;
    while (!bus.RSP_VALID && n < 50) begin @(negedge clk); n++; end
    chk("bp_rsp_valid_seen", bus.RSP_VALID, 1);
    present(1, 32'h0000_7004, 32'h1357_9BDF, 0, 32'h0, 0, 1'b1, 1, 32'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", bus.CMD_READY, 0);
      chk("bp_psel", bus.PSEL, 0);
      chk("bp_rsp_hold", bus.RSP_VALID, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.RSP_READY = 1'b1;
    accept(t0);
    drain();

    // Back-to-back zero-wait writes: 4-cycle command period.
    send(1, 32'h0000_8000, 32'h0000_0001, 0, 32'h0, 0, 1, 32'h0, 0, 0, t0);
    send(1, 32'h0000_8004, 32'h0000_0002, 0, 32'h0, 0, 1, 32'h0, 0, 0, t1);
    send(1, 32'h0000_8008, 32'h0000_0003, 0, 32'h0, 0, 1, 32'h0, 0, 0, t2);
    chk("b2b_period_1", t1 - t0, 4);
    chk("b2b_period_2", t2 - t1, 4);
    drain();

    // Reset while in ACCESS.
    ignore_apb = 1'b1;
    present(0, 32'h0000_9000, 32'h0, NEVER, 32'h0, 0, 1'b0, 0, 32'h0, 0, 0);
    accept(t0);
    n = 0;
    while (!bus.PENABLE && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_penable_seen", {bus.PSEL, bus.PENABLE}, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_psel", bus.PSEL, 0);
    chk("rst_mid_penable", bus.PENABLE, 0);
    chk("rst_mid_rsp_valid", bus.RSP_VALID, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_ready", bus.CMD_READY, 1);
    @(negedge clk);
    ignore_apb = 1'b0;
    chk("rst_mid_no_rsp", bus.RSP_VALID, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
